// File: rtl/timestamp_extract_proc_pkg.sv
// Shared blueswitch parameters: extractor FSM encodings, statistics init
// values and a saturating counter helper.
package nf_sume_blueswitch_pkg;

  typedef enum logic [1:0] {
    TS_IDLE      = 2'd0,
    TS_IN_PKT    = 2'd1,
    TS_CAPTURED  = 2'd2,
    TS_DONE_WAIT = 2'd3
  } tsState_t;

  localparam logic [63:0] STATS_INIT_MIN = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [7:0]  WORD_CNT_MAX   = 8'hFF;

  // Event counters hold at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] satInc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/timestamp_extract_proc_if.sv
// AXI4-Stream bundle watched by the timestamp extractor; the extractor
// only observes it through the monitor view and never drives tready.
interface timestamp_extract_proc_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master  (output tdata, tvalid, tlast, input tready);
  modport slave   (input tdata, tvalid, tlast, output tready);
  modport monitor (input tdata, tvalid, tready, tlast);
endinterface

// File: rtl/timestamp_extract_proc_stats.sv
// Latency statistics: running min/max plus saturating sample, error and
// short-packet counters. A clear pulse overrides any coincident update.
module ts_latency_stats
  import nf_sume_blueswitch_pkg::*;
(
  input  logic        axi_aclk,
  input  logic        axi_reset,
  input  logic        i_clear,
  input  logic        i_sampleValid,
  input  logic        i_sampleErr,
  input  logic [63:0] i_sample,
  input  logic        i_shortPkt,
  output logic [63:0] o_latencyMin,
  output logic [63:0] o_latencyMax,
  output logic [31:0] o_sampleCnt,
  output logic [31:0] o_tsErrCnt,
  output logic [31:0] o_shortPktCnt
);

  logic [63:0] r_min;
  logic [63:0] r_max;
  logic [31:0] r_sampleCnt;
  logic [31:0] r_errCnt;
  logic [31:0] r_shortCnt;

  // Error samples are counted but kept out of min/max.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_min       <= STATS_INIT_MIN;
      r_max       <= '0;
      r_sampleCnt <= '0;
      r_errCnt    <= '0;
      r_shortCnt  <= '0;
    end else if (i_clear) begin
      r_min       <= STATS_INIT_MIN;
      r_max       <= '0;
      r_sampleCnt <= '0;
      r_errCnt    <= '0;
      r_shortCnt  <= '0;
    end else begin
      if (i_sampleValid) begin
        r_sampleCnt <= satInc32(r_sampleCnt);
        if (i_sampleErr) begin
          r_errCnt <= satInc32(r_errCnt);
        end else begin
          if (i_sample < r_min) r_min <= i_sample;
          if (i_sample > r_max) r_max <= i_sample;
        end
      end
      if (i_shortPkt) r_shortCnt <= satInc32(r_shortCnt);
    end
  end

  assign o_latencyMin  = r_min;
  assign o_latencyMax  = r_max;
  assign o_sampleCnt   = r_sampleCnt;
  assign o_tsErrCnt    = r_errCnt;
  assign o_shortPktCnt = r_shortCnt;

endmodule

// File: rtl/timestamp_extract_proc.sv
// Passive AXI-Stream monitor: pulls a 64-bit timestamp from a chosen packet
// word, measures latency against a reference counter and optionally strips it.
module timestamp_extract_proc
  import nf_sume_blueswitch_pkg::*;
#(
  parameter int TS_POSITION_WIDTH    = 8,
  parameter int C_S_AXIS_TDATA_WIDTH = 256
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [63:0]                     ref_counter,
  input  logic                            ts_valid,
  input  logic [TS_POSITION_WIDTH-1:0]    ts_position,
  input  logic                            strip_en,
  input  logic                            stats_clear,
  timestamp_extract_proc_if.monitor       s_axis,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata_ts_strip,
  output logic [63:0]                     latency,
  output logic                            latency_valid,
  output logic [63:0]                     latency_min,
  output logic [63:0]                     latency_max,
  output logic [31:0]                     sample_cnt,
  output logic [31:0]                     ts_err_cnt,
  output logic [31:0]                     short_pkt_cnt
);

  tsState_t                        r_state;
  tsState_t                        w_nextState;
  logic [7:0]                      r_wordCnt;
  logic [63:0]                     r_latency;
  logic                            r_latencyValid;
  logic                            r_latencyErr;
  logic                            w_beat;
  logic                            w_posMatch;
  logic                            w_capture;
  logic                            w_shortPkt;
  logic                            w_tsErr;
  logic [63:0]                     w_ts;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] w_stripData;

  assign w_beat     = s_axis.tvalid & s_axis.tready;
  assign w_posMatch = (r_wordCnt == ts_position[7:0]);
  assign w_ts       = s_axis.tdata[63:0];
  assign w_tsErr    = (w_ts > ref_counter);

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) r_state <= TS_IDLE;
    else           r_state <= w_nextState;
  end

  // Only IDLE/IN_PKT look at the position word, so a packet decides once
  // and a counter stuck at 255 cannot trigger a second capture.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_shortPkt  = 1'b0;
    if (w_beat) begin
      case (r_state)
        TS_IDLE, TS_IN_PKT: begin
          if (w_posMatch) begin
            w_capture   = ts_valid;
            w_nextState = ts_valid ? TS_CAPTURED : TS_DONE_WAIT;
          end else begin
            w_shortPkt  = s_axis.tlast & ts_valid;
            w_nextState = TS_IN_PKT;
          end
          if (s_axis.tlast) w_nextState = TS_IDLE;
        end
        default: begin
          if (s_axis.tlast) w_nextState = TS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wordCnt <= '0;
    end else if (w_beat) begin
      if (s_axis.tlast)                   r_wordCnt <= '0;
      else if (r_wordCnt != WORD_CNT_MAX) r_wordCnt <= r_wordCnt + 8'd1;
    end
  end

  // A timestamp from the future reports zero and is flagged as an error.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_latency      <= '0;
      r_latencyValid <= 1'b0;
      r_latencyErr   <= 1'b0;
    end else begin
      r_latencyValid <= w_capture;
      if (w_capture) begin
        r_latencyErr <= w_tsErr;
        r_latency    <= w_tsErr ? 64'd0 : (ref_counter - w_ts);
      end
    end
  end

  always_comb begin
    w_stripData = s_axis.tdata;
    if (w_capture && strip_en) w_stripData[63:0] = '0;
  end

  assign s_axis_tdata_ts_strip = w_stripData;
  assign latency               = r_latency;
  assign latency_valid         = r_latencyValid;

  ts_latency_stats u_stats (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .i_clear       (stats_clear),
    .i_sampleValid (r_latencyValid),
    .i_sampleErr   (r_latencyErr),
    .i_sample      (r_latency),
    .i_shortPkt    (w_shortPkt),
    .o_latencyMin  (latency_min),
    .o_latencyMax  (latency_max),
    .o_sampleCnt   (sample_cnt),
    .o_tsErrCnt    (ts_err_cnt),
    .o_shortPktCnt (short_pkt_cnt)
  );

endmodule

// File: tb/tb_timestamp_extract_proc.sv
// Bench for timestamp_extract_proc: a packet-level reference model checked
// every cycle, plus literal expectations after each directed packet.
module tb_timestamp_extract_proc;

  localparam int          DW       = 256;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          axi_aclk = 1'b0;
  logic          axi_reset;
  logic [63:0]   ref_counter;
  logic          ts_valid;
  logic [7:0]    ts_position;
  logic          strip_en;
  logic          stats_clear;
  logic [DW-1:0] s_axis_tdata_ts_strip;
  logic [63:0]   latency;
  logic          latency_valid;
  logic [63:0]   latency_min;
  logic [63:0]   latency_max;
  logic [31:0]   sample_cnt;
  logic [31:0]   ts_err_cnt;
  logic [31:0]   short_pkt_cnt;

  timestamp_extract_proc_if #(.DATA_WIDTH(DW)) s_if ();

  timestamp_extract_proc #(
    .TS_POSITION_WIDTH    (8),
    .C_S_AXIS_TDATA_WIDTH (DW)
  ) dut (
    .axi_aclk              (axi_aclk),
    .axi_reset             (axi_reset),
    .ref_counter           (ref_counter),
    .ts_valid              (ts_valid),
    .ts_position           (ts_position),
    .strip_en              (strip_en),
    .stats_clear           (stats_clear),
    .s_axis                (s_if),
    .s_axis_tdata_ts_strip (s_axis_tdata_ts_strip),
    .latency               (latency),
    .latency_valid         (latency_valid),
    .latency_min           (latency_min),
    .latency_max           (latency_max),
    .sample_cnt            (sample_cnt),
    .ts_err_cnt            (ts_err_cnt),
    .short_pkt_cnt         (short_pkt_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkVal64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkOutput(name, 256'(act), 256'(exp));
  endtask

  // Reference model: packet word index and a per-packet "decided" flag,
  // latency result of the last edge, and plain-integer statistics.
  int          mWord;
  int          mSample;
  int          mErrCnt;
  int          mShort;
  bit          mDecided;
  bit          mLatValid;
  bit          mLatErr;
  bit          mCap;
  logic [63:0] mLat;
  logic [63:0] mMin;
  logic [63:0] mMax;
  logic [63:0] mTs;

  always @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      mWord = 0; mDecided = 0; mLatValid = 0; mLatErr = 0; mLat = '0;
      mMin = ALL_ONES; mMax = '0; mSample = 0; mErrCnt = 0; mShort = 0;
    end else begin
      if (stats_clear) begin
        mMin = ALL_ONES; mMax = '0; mSample = 0; mErrCnt = 0; mShort = 0;
      end else if (mLatValid) begin
        mSample++;
        if (mLatErr) mErrCnt++;
        else begin
          if (mLat < mMin) mMin = mLat;
          if (mLat > mMax) mMax = mLat;
        end
      end
      mCap = 0;
      if (s_if.tvalid && s_if.tready) begin
        if (!mDecided && mWord == int'(ts_position)) begin
          mDecided = 1;
          mCap     = ts_valid;
        end else if (!mDecided && s_if.tlast && ts_valid && !stats_clear) begin
          mShort++;
        end
        if (s_if.tlast) begin
          mWord = 0; mDecided = 0;
        end else if (mWord < 255) begin
          mWord++;
        end
      end
      mLatValid = mCap;
      if (mCap) begin
        mTs     = s_if.tdata[63:0];
        mLatErr = (mTs > ref_counter);
        mLat    = mLatErr ? 64'd0 : ref_counter - mTs;
      end
    end
  end

  logic [DW-1:0] expStrip;

  always @(negedge axi_aclk) begin
    expStrip = s_if.tdata;
    if (s_if.tvalid && s_if.tready && !mDecided && mWord == int'(ts_position) && ts_valid && strip_en)
      expStrip[63:0] = '0;
    checkOutput("cmp_strip", s_axis_tdata_ts_strip, expStrip);
    checkOutput("cmp_latency_valid", 256'(latency_valid), 256'(mLatValid));
    checkVal64("cmp_latency", latency, mLat);
    checkVal64("cmp_latency_min", latency_min, mMin);
    checkVal64("cmp_latency_max", latency_max, mMax);
    checkVal64("cmp_sample_cnt", 64'(sample_cnt), 64'(mSample));
    checkVal64("cmp_ts_err_cnt", 64'(ts_err_cnt), 64'(mErrCnt));
    checkVal64("cmp_short_pkt_cnt", 64'(short_pkt_cnt), 64'(mShort));
  end

  logic [DW-1:0] lastStrip;
  logic [DW-1:0] capStrip;
  logic [DW-1:0] firstStrip;
  logic [DW-1:0] refWord;

  function automatic logic [DW-1:0] makeWord(input int w, input int pos, input logic [63:0] ts);
    logic [DW-1:0] d;
    d[255:64] = {6{16'hC0DE, w[15:0]}};
    d[63:0]   = (w == pos) ? ts : (64'h1111_0000_0000_0000 + 64'(w));
    return d;
  endfunction

  // Drive one cycle of inputs, sample the combinational strip output,
  // then return just after the edge that consumed them.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic vld, input logic rdy,
                               input logic last, input logic tsv, input logic [7:0] pos,
                               input logic strip, input logic clr, input logic [63:0] refv);
    s_if.tdata   = data;
    s_if.tvalid  = vld;
    s_if.tready  = rdy;
    s_if.tlast   = last;
    ts_valid     = tsv;
    ts_position  = pos;
    strip_en     = strip;
    stats_clear  = clr;
    ref_counter  = refv;
    #2;
    lastStrip = s_axis_tdata_ts_strip;
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus('0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ref_counter);
  endtask

  task automatic sendPacket(input int nBeats, input int pos, input logic [63:0] ts,
                            input logic [63:0] refv, input bit tsv, input bit strip,
                            input bit stall, input int clearBeat);
    for (int w = 0; w < nBeats; w++) begin
      if (stall)
        applyStimulus(makeWord(w, pos, ts), 1'b1, 1'b0, (w == nBeats - 1), tsv, 8'(pos),
                      strip, 1'b0, refv);
      applyStimulus(makeWord(w, pos, ts), 1'b1, 1'b1, (w == nBeats - 1), tsv, 8'(pos),
                    strip, (w == clearBeat), refv);
      if (w == 0)   firstStrip = lastStrip;
      if (w == pos) capStrip   = lastStrip;
      if (w == pos && tsv) checkOutput("lat_valid_pulse", 256'(latency_valid), 256'(1'b1));
    end
    idleCycles(2);
  endtask

  initial begin
    axi_reset   = 1'b1;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tready = 1'b1;
    s_if.tlast  = 1'b0;
    ts_valid    = 1'b0;
    ts_position = 8'd0;
    strip_en    = 1'b0;
    stats_clear = 1'b0;
    ref_counter = 64'd0;
    repeat (3) @(posedge axi_aclk);
    #1;
    checkVal64("rst_latency", latency, 64'd0);
    checkOutput("rst_latency_valid", 256'(latency_valid), 256'(1'b0));
    checkVal64("rst_min", latency_min, ALL_ONES);
    checkVal64("rst_max", latency_max, 64'd0);
    checkVal64("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    axi_reset = 1'b0;
    idleCycles(2);

    $display("[TB] basic latency packets");
    sendPacket(4, 2, 64'd1000, 64'd1250, 1, 0, 0, -1);
    checkVal64("pktA_latency", latency, 64'd250);
    checkVal64("pktA_sample_cnt", 64'(sample_cnt), 64'd1);
    checkVal64("pktA_min", latency_min, 64'd250);
    checkVal64("pktA_max", latency_max, 64'd250);
    sendPacket(3, 1, 64'd5000, 64'd5100, 1, 0, 0, -1);
    checkVal64("pktB_latency", latency, 64'd100);
    sendPacket(5, 0, 64'd600, 64'd1000, 1, 0, 0, -1);
    checkVal64("pktC_latency", latency, 64'd400);
    checkVal64("pktC_min", latency_min, 64'd100);
    checkVal64("pktC_max", latency_max, 64'd400);
    checkVal64("pktC_sample_cnt", 64'(sample_cnt), 64'd3);

    $display("[TB] future timestamp and short packet");
    sendPacket(4, 3, 64'd2000, 64'd1500, 1, 0, 0, -1);
    checkVal64("pktD_latency", latency, 64'd0);
    checkVal64("pktD_err_cnt", 64'(ts_err_cnt), 64'd1);
    checkVal64("pktD_sample_cnt", 64'(sample_cnt), 64'd4);
    checkVal64("pktD_min", latency_min, 64'd100);
    checkVal64("pktD_max", latency_max, 64'd400);
    sendPacket(2, 5, 64'd9, 64'd99, 1, 0, 0, -1);
    checkVal64("pktE_short_cnt", 64'(short_pkt_cnt), 64'd1);
    checkVal64("pktE_sample_cnt", 64'(sample_cnt), 64'd4);

    $display("[TB] long packet with saturating word counter");
    sendPacket(300, 255, 64'd7000, 64'd7777, 1, 0, 0, -1);
    checkVal64("pktF_latency", latency, 64'd777);
    checkVal64("pktF_sample_cnt", 64'(sample_cnt), 64'd5);

    $display("[TB] strip with stalled beats");
    sendPacket(4, 1, 64'd300, 64'd350, 1, 1, 1, -1);
    checkVal64("pktG_latency", latency, 64'd50);
    checkVal64("pktG_min", latency_min, 64'd50);
    refWord = makeWord(0, 1, 64'd300);
    checkOutput("pktG_strip_other_beat", firstStrip, refWord);
    refWord = makeWord(1, 1, 64'd300);
    checkVal64("pktG_strip_low", capStrip[63:0], 64'd0);
    checkOutput("pktG_strip_high", 256'(capStrip[255:64]), 256'(refWord[255:64]));

    $display("[TB] single-beat packet");
    sendPacket(1, 0, 64'd10, 64'd20, 1, 0, 0, -1);
    checkVal64("pktH_latency", latency, 64'd10);
    sendPacket(2, 1, 64'd100, 64'd130, 1, 0, 0, -1);
    checkVal64("pktI_latency", latency, 64'd30);
    checkVal64("pktI_sample_cnt", 64'(sample_cnt), 64'd8);
    checkVal64("pktI_min", latency_min, 64'd10);
    checkVal64("pktI_max", latency_max, 64'd777);

    $display("[TB] reset mid-packet");
    applyStimulus(makeWord(0, 0, 64'd40), 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 64'd90);
    s_if.tdata = makeWord(1, 0, 64'd40);
    #2;
    axi_reset = 1'b1;
    @(posedge axi_aclk);
    #1;
    idleCycles(2);
    axi_reset = 1'b0;
    idleCycles(2);
    checkOutput("rst2_latency_valid", 256'(latency_valid), 256'(1'b0));
    checkVal64("rst2_latency", latency, 64'd0);
    checkVal64("rst2_sample_cnt", 64'(sample_cnt), 64'd0);
    checkVal64("rst2_min", latency_min, ALL_ONES);
    sendPacket(2, 5, 64'd1, 64'd2, 1, 0, 0, -1);
    sendPacket(3, 1, 64'd100, 64'd190, 1, 0, 0, -1);
    checkVal64("pktK_latency", latency, 64'd90);
    checkVal64("pktK_short_cnt", 64'(short_pkt_cnt), 64'd1);

    $display("[TB] stats_clear with capture and with update");
    sendPacket(4, 2, 64'd50, 64'd80, 1, 0, 0, 2);
    checkVal64("pktJ_latency", latency, 64'd30);
    checkVal64("pktJ_sample_cnt", 64'(sample_cnt), 64'd1);
    checkVal64("pktJ_min", latency_min, 64'd30);
    checkVal64("pktJ_max", latency_max, 64'd30);
    checkVal64("pktJ_short_cnt", 64'(short_pkt_cnt), 64'd0);
    sendPacket(3, 0, 64'd0, 64'd5, 1, 0, 0, 1);
    checkVal64("pktL_latency", latency, 64'd5);
    checkVal64("pktL_sample_cnt", 64'(sample_cnt), 64'd0);
    checkVal64("pktL_min", latency_min, ALL_ONES);
    checkVal64("pktL_max", latency_max, 64'd0);

    idleCycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
